// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, PC step, NOP encoding
// and saturating-increment helpers for the optional IFETCH_PERF_EN counters.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam int          PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO for ifetch_queue: DEPTH entries (power of two), push/pop/flush,
// exposes the head entry and occupancy count.
module ifq_fifo #(
    parameter int ENTRY_W = 64,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       push_data,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: single-outstanding imem requests, prefetch FIFO,
// stall/redirect handling. Optional perf counters under IFETCH_PERF_EN.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clka,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    fetch_state_e       state_q;
    logic               req_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  fetch_pc_q;

    logic               push_s;
    logic               pop_s;
    logic               valid_s;
    logic               slots_free_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_after_s;
    logic [ENTRY_W-1:0] head_s;
    logic [ADDR_W-1:0]  next_pc_s;

    // Occupancy after this cycle's push/pop decides whether a new request fits.
    always_comb begin
        valid_s       = (count_s != '0);
        pop_s         = valid_s && !stall && !redirect_valid;
        push_s        = (state_q == ST_WAIT) && imem_ack && !redirect_valid;
        count_after_s = count_s - CNT_W'(pop_s) + CNT_W'(push_s);
        slots_free_s  = (count_after_s < CNT_W'(DEPTH));
        next_pc_s     = fetch_pc_q + ADDR_W'(PC_INC);
    end

    ifq_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clka),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .push_data ({imem_rdata, addr_q}),
        .head      (head_s),
        .count     (count_s)
    );

    // Request FSM; req/addr are held from issue until the ack cycle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (slots_free_s) begin
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack && redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        req_q      <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_pc_s;
                        if (slots_free_s) begin
                            addr_q <= next_pc_s;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_s;
    assign instr_out   = head_s[ENTRY_W-1:ADDR_W];
    assign instr_pc    = head_s[ADDR_W-1:0];

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    // Saturating performance counters.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (valid_s && stall) begin
                stall_cycles_q <= sat_inc32(stall_cycles_q);
            end
            if (redirect_valid) begin
                flush_count_q <= sat_inc16(flush_count_q);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: RAM responder returns word k at PC 4k,
// monitor compares every consumed head against the expected fetch path.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [31:0] sc0;
    logic [15:0] fc0;
`endif

    int ack_delay = 1;
    bit ack_en = 1'b1;
    bit ack_force = 1'b0;
    int age = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_popped = 0;
    logic [63:0] sb_q[$];
    logic [31:0] old_addr;
    bit found;

    ifetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'd0)) dut (
        .clka           (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_path(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            pc = start + 32'(4 * i);
            sb_q.push_back({pc >> 2, pc});
        end
    endtask

    task automatic wait_pops(input int n);
        int target;
        target = n_popped + n;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_popped >= target) return;
        end
        check("pop_timeout", 64'(n_popped), 64'(target));
    endtask

    // RAM responder: acks a request once it has been pending ack_delay cycles.
    always @(negedge clk) begin
        if (imem_ack || !imem_req) age = 0;
        if (imem_req) age = age + 1;
        imem_ack   = ack_force || (ack_en && imem_req && (age > ack_delay));
        imem_rdata = ack_force ? 32'hDEAD_BEEF : (imem_addr >> 2);
    end

    // Monitor: every cycle that will pop the head is checked against the scoreboard.
    initial begin : monitor
        logic [63:0] exp_e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_valid && !stall && !redirect_valid) begin
                n_popped++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h at pc %0h expected none", instr_out, instr_pc);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("head_word_pc", {instr_out, instr_pc}, exp_e);
                end
            end
        end
    end

    initial begin : main
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_out", 64'(instr_out), 64'd0);
        check("rst_pc", 64'(instr_pc), 64'd0);

        // Streaming from reset, 1 word per 2 cycles.
        expect_path(32'd0, 64);
        @(negedge clk);
        rst = 1'b0;
        wait_pops(4);

        // Stall long enough to fill the FIFO.
        stall = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("full_req_low", 64'(imem_req), 64'd0);
        check("stall_valid", 64'(instr_valid), 64'd1);
        check("stall_head_pc", 64'(instr_pc), 64'h10);
        stall = 1'b0;
        wait_pops(6);

        // Redirect while a request is pending; its ack arrives two cycles later.
        ack_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (imem_req && age == 2 && !instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("sync_wait", 64'(found), 64'd1);
        old_addr = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        sb_q.delete();
        expect_path(32'h40, 64);
        @(negedge clk);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (imem_req && imem_addr != old_addr) begin
                check("redirect_addr", 64'(imem_addr), 64'h40);
                found = 1'b1;
                break;
            end
        end
        check("redirect_req_seen", 64'(found), 64'd1);
        wait_pops(3);

        // Redirect coinciding with an ack and a would-be pop.
        ack_delay = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (imem_ack && instr_valid && imem_req) begin
                found = 1'b1;
                break;
            end
        end
        check("sync_ack_pop", 64'(found), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        sb_q.delete();
        expect_path(32'h80, 64);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("flush_empty", 64'(instr_valid), 64'd0);
        wait_pops(4);

`ifdef IFETCH_PERF_EN
        ack_delay = 1;
        @(negedge clk);
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("perf_sync", 64'(found), 64'd1);
        sc0 = stall_cycles;
        fc0 = flush_count;
        repeat (5) @(negedge clk);
        #1;
        check("perf_stall_cycles", 64'(stall_cycles - sc0), 64'd5);
        stall = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            redirect_valid = 1'b1;
            redirect_pc = 32'h100 * 32'(r + 1);
            sb_q.delete();
            expect_path(redirect_pc, 64);
            @(negedge clk);
            redirect_valid = 1'b0;
        end
        #1;
        check("perf_flush_count", 64'(flush_count - fc0), 64'd2);
        wait_pops(3);
`endif

        // Reset in the middle of a pending request, then a stray ack.
        ack_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (imem_req && !imem_ack) begin
                found = 1'b1;
                break;
            end
        end
        check("sync_mid_wait", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_req", 64'(imem_req), 64'd0);
        check("midrst_valid", 64'(instr_valid), 64'd0);
        check("midrst_addr", 64'(imem_addr), 64'd0);
        sb_q.delete();
        @(negedge clk);
        #1;
        ack_force = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        ack_force = 1'b0;
        ack_delay = 1;
        @(negedge clk);
        #1;
        check("post_rst_req", 64'(imem_req), 64'd1);
        check("post_rst_addr", 64'(imem_addr), 64'd0);
        check("stray_ack_ignored", 64'(instr_valid), 64'd0);
        expect_path(32'd0, 32);
        wait_pops(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the CPU's five-slot instruction pipeline; feeds the decode slot.
- Holds the PC and issues word requests to the instruction RAM over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them in order with their PC.
- Honours decode back-pressure (stall) and branch/jump redirects, which flush all buffered and in-flight fetches.

Parameters:
- ADDR_W, 32, PC / instruction-RAM byte-address width.
- DATA_W, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clka  in  1  fetch clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request to instruction RAM.
- imem_addr  out  ADDR_W  byte address of the request.
- imem_ack  in  1  request accepted; imem_rdata valid this cycle.
- imem_rdata  in  DATA_W  fetched word.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  load a new PC (taken branch/jump).
- redirect_pc  in  ADDR_W  redirect target; word aligned.
- instr_valid  out  1  FIFO head valid.
- instr_out  out  DATA_W  FIFO head word.
- instr_pc  out  ADDR_W  PC of the FIFO head word.

Behaviour:
- Interface: single clock clka; rst is asynchronous and active-high. While rst is high: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, FIFO empty, fetch_pc=RESET_PC, state IDLE.
- State machine (at most one outstanding request):
  - IDLE to WAIT: when slots_free is true, assert imem_req with imem_addr=fetch_pc. slots_free means count < DEPTH, evaluated after this cycle's pop.
  - WAIT to IDLE: on imem_ack, push {imem_rdata, imem_addr} into the FIFO and set fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - WAIT to DISCARD: on redirect_valid without imem_ack.
  - DISCARD to IDLE: on imem_ack; the returned word is dropped and not pushed.
- Handshake:
  - imem_req and imem_addr stay stable from assertion until the ack cycle. A request is never withdrawn, including during a redirect.
  - imem_req deasserts the cycle after the ack unless a new request is issued immediately.
- Latency:
  - First request is visible in the first cycle after rst deasserts.
  - A word acked at edge N appears on instr_valid/instr_out after edge N.
  - Back-to-back ack every other cycle gives 1 word per 2 cycles. A same-cycle re-request after an ack in IDLE is permitted, giving 1 word per cycle when ack is combinational.
- Consumer: a pop occurs when instr_valid && !stall && !redirect_valid. The head is held unchanged while stall=1.
- Redirect (highest priority):
  - FIFO is flushed and instr_valid=0 after the edge.
  - fetch_pc = redirect_pc.
  - An ack in the same cycle as the redirect is discarded.
  - In IDLE, the next request goes to redirect_pc in the following cycle.
  - A redirect during DISCARD overwrites fetch_pc (the last redirect wins).
- Full: when count==DEPTH, no request is issued. Because slots are reserved by the single-outstanding rule, a push can never overflow.
- Empty: instr_valid=0. instr_out and instr_pc hold their last value (don't-care).
- Simultaneous push and pop: count is unchanged; the head advances.
- Reset mid-request: all state clears immediately. An ack arriving after reset release with no request outstanding is ignored.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds output ports stall_cycles (32) and flush_count (16), both reset to 0.
  - stall_cycles increments on each cycle with instr_valid && stall.
  - flush_count increments on each redirect_valid cycle.
  - Both saturate at all-ones.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds: the fetch-state enum (IDLE/WAIT/DISCARD), the PC increment constant 4, and the NOP encoding used by decode when instr_valid=0.
- One sub-module, ifq_fifo: a DEPTH-entry synchronous FIFO with push, pop, flush, count and head outputs, with asynchronous reset.

Test Plan:
- Reset release with imem_ack tied high after a 1-cycle delay, RAM word k = k: instr_out sequence 0,1,2,3 at PCs 0,4,8,12; no gaps beyond handshake latency.
- stall held 10 cycles: FIFO fills to 4; imem_req stays low while full; after stall drops, order continues 4,5,... with no loss or duplication.
- redirect_valid with redirect_pc=0x40 while WAIT, then ack 2 cycles later: acked word dropped; next imem_addr=0x40; next instr_pc=0x40.
- redirect in the same cycle as imem_ack and a pop: FIFO empty next cycle; no word from the old path ever appears.
- rst pulsed mid-WAIT: imem_req=0 and instr_valid=0 immediately; after release, first request at RESET_PC; a stray ack is ignored.
- IFETCH_PERF_EN defined, with 5 stalled-valid cycles and 2 redirects: stall_cycles=5 and flush_count=2.
